// File: rtl/cylon_pkg.sv
// Shared types and constants for the cylon LED bus decoder.
// Holds the decoder FSM state encoding, the default bus width and the
// matching position index width.
package cylon_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int POS_W         = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRACK_UP   = 2'd1,
    TRACK_DOWN = 2'd2,
    FAULT      = 2'd3
  } cylon_state_t;

endpackage

// File: rtl/cylon_onehot_enc.sv
// Combinational one-hot to index encoder.
// idx is the OR of the indices of all set bits, so it is the bit number
// whenever is_onehot is high and a don't-care otherwise.
module cylon_onehot_enc
  import cylon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDX_W = POS_W
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);

  logic seen;
  logic multi;

  // Scan every bit, tracking "at least one" and "more than one" set.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each loop iteration
    // sees the value produced by the previous one.
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx   = idx | IDX_W'(i);
      end
    end
    is_onehot = seen & ~multi;
  end

endmodule

// File: rtl/cylon_led_decoder.sv
// Reader/checker for the cylon LED bus.
// Stage 1 registers led; stage 2 decodes it, tracks the lit position and
// scan direction, counts end-to-end sweeps and flags one-hot, jump and
// stall violations. Outputs follow a bus change by two cycles.
// Optional: define CYLON_DEC_STICKY_ERR_EN to make the error outputs latch
// high until btnC instead of pulsing for one cycle.
module cylon_led_decoder
  import cylon_pkg::*;
#(
  parameter int          WIDTH        = WIDTH_DEFAULT,
  parameter logic [27:0] STALL_CYCLES = 28'd100_000_000
) (
  input  logic                     clk,
  input  logic                     btnC,
  input  logic [WIDTH-1:0]         led,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic                     dir,
  output logic                     step,
  output logic [15:0]              sweep_count,
  output logic                     err_onehot,
  output logic                     err_jump,
  output logic                     err_stall
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] led_s1;
  logic [WIDTH-1:0] led_s1_prev;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_onehot;
  logic             change;

  cylon_state_t     state;
  cylon_state_t     state_n;
  logic [IDX_W-1:0] pos_n;
  logic             pos_valid_n;
  logic             dir_n;
  logic             step_n;
  logic [15:0]      sweep_count_n;
  logic             onehot_evt;
  logic             jump_evt;
  logic             stall_evt;
  logic             err_onehot_n;
  logic             err_jump_n;
  logic             err_stall_n;
  logic [27:0]      stall_cnt;
  logic [27:0]      stall_cnt_n;
  logic             up_ok;
  logic             down_ok;

  // Stage 1: register the bus and keep the previous sample for change detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    if (btnC) begin
      led_s1      <= '0;
      led_s1_prev <= '0;
    end else begin
      led_s1      <= led;
      led_s1_prev <= led_s1;
    end
  end

  assign change = (led_s1 != led_s1_prev);

  cylon_onehot_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec       (led_s1),
    .idx       (enc_idx),
    .is_onehot (enc_onehot)
  );

  // Legal single steps; the range guards stop 0 <-> WIDTH-1 from wrapping.
  assign up_ok   = (pos != IDX_MAX) && (enc_idx == pos + IDX_W'(1));
  assign down_ok = (pos != '0)      && (enc_idx == pos - IDX_W'(1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (btnC) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state, tracking and error decisions for stage 2.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_n       = state;
    pos_n         = pos;
    pos_valid_n   = pos_valid;
    dir_n         = dir;
    step_n        = 1'b0;
    sweep_count_n = sweep_count;
    onehot_evt    = 1'b0;
    jump_evt      = 1'b0;

    case (state)
      IDLE, FAULT: begin
        // Re-acquire on the first one-hot sample; no step is produced.
        if (change) begin
          if (enc_onehot) begin
            pos_n       = enc_idx;
            pos_valid_n = 1'b1;
            state_n     = (enc_idx == IDX_MAX) ? TRACK_DOWN : TRACK_UP;
          end else begin
            onehot_evt  = 1'b1;
            pos_valid_n = 1'b0;
          end
        end
      end
      TRACK_UP, TRACK_DOWN: begin
        if (change) begin
          if (!enc_onehot) begin
            onehot_evt  = 1'b1;
            pos_valid_n = 1'b0;
            state_n     = FAULT;
          end else if (up_ok || down_ok) begin
            step_n  = 1'b1;
            dir_n   = up_ok;
            pos_n   = enc_idx;
            state_n = up_ok ? TRACK_UP : TRACK_DOWN;
            if (enc_idx == IDX_MAX || enc_idx == '0) begin
              sweep_count_n = sweep_count + 16'd1;
            end
          end else begin
            jump_evt = 1'b1;
            state_n  = FAULT;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Stall counter: held at zero while idle or on a change, saturates.
    stall_cnt_n = stall_cnt;
    stall_evt   = 1'b0;
    if (state == IDLE || change) begin
      stall_cnt_n = '0;
    end else if (stall_cnt != STALL_CYCLES) begin
      stall_cnt_n = stall_cnt + 28'd1;
      stall_evt   = (stall_cnt_n == STALL_CYCLES);
    end

`ifdef CYLON_DEC_STICKY_ERR_EN
    err_onehot_n = err_onehot | onehot_evt;
    err_jump_n   = err_jump   | jump_evt;
    err_stall_n  = err_stall  | stall_evt;
`else
    err_onehot_n = onehot_evt;
    err_jump_n   = jump_evt;
    err_stall_n  = stall_evt;
`endif
  end

  // Stage 2 output and counter registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and overrides every other update.
    if (btnC) begin
      pos         <= '0;
      pos_valid   <= 1'b0;
      dir         <= 1'b0;
      step        <= 1'b0;
      sweep_count <= '0;
      err_onehot  <= 1'b0;
      err_jump    <= 1'b0;
      err_stall   <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      pos         <= pos_n;
      pos_valid   <= pos_valid_n;
      dir         <= dir_n;
      step        <= step_n;
      sweep_count <= sweep_count_n;
      err_onehot  <= err_onehot_n;
      err_jump    <= err_jump_n;
      err_stall   <= err_stall_n;
      stall_cnt   <= stall_cnt_n;
    end
  end

endmodule

// File: tb/tb_cylon_led_decoder.sv
// Self-checking bench for cylon_led_decoder: directed test-plan steps plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_cylon_led_decoder;

  localparam int W     = 16;
  localparam int STALL = 500;

  logic        clk;
  logic        btnC;
  logic [15:0] led;
  logic [3:0]  pos;
  logic        pos_valid;
  logic        dir;
  logic        step;
  logic [15:0] sweep_count;
  logic        err_onehot;
  logic        err_jump;
  logic        err_stall;

  int n_checks = 0;
  int n_fail   = 0;
  int steps_seen;

  cylon_led_decoder #(
    .WIDTH        (W),
    .STALL_CYCLES (28'(STALL))
  ) dut (
    .clk         (clk),
    .btnC        (btnC),
    .led         (led),
    .pos         (pos),
    .pos_valid   (pos_valid),
    .dir         (dir),
    .step        (step),
    .sweep_count (sweep_count),
    .err_onehot  (err_onehot),
    .err_jump    (err_jump),
    .err_stall   (err_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: two-sample delay line, then rules applied with integers.
  typedef enum {M_IDLE, M_UP, M_DOWN, M_FAULT} m_mode_t;
  m_mode_t     m_mode = M_IDLE;
  logic [15:0] m_s1 = '0;
  logic [15:0] m_prev = '0;
  int          m_pos = 0;
  int          m_sweep = 0;
  int          m_cnt = 0;
  bit          m_valid = 0, m_dir = 0, m_step = 0;
  bit          m_eoh = 0, m_ej = 0, m_est = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [15:0] l);
    bit chg, oh, e_oh, e_j, e_st;
    int ix, d;
    if (rst) begin
      m_mode = M_IDLE; m_s1 = '0; m_prev = '0; m_pos = 0; m_sweep = 0; m_cnt = 0;
      m_valid = 0; m_dir = 0; m_step = 0; m_eoh = 0; m_ej = 0; m_est = 0;
      return;
    end
    chg  = (m_s1 != m_prev);
    oh   = ($countones(m_s1) == 1);
    ix   = oh ? $clog2(m_s1) : 0;
    e_oh = 0; e_j = 0; e_st = 0; m_step = 0;
    if (m_mode == M_IDLE || chg) m_cnt = 0;
    else if (m_cnt < STALL) begin
      m_cnt++;
      e_st = (m_cnt == STALL);
    end
    if (chg) begin
      if (m_mode == M_IDLE || m_mode == M_FAULT) begin
        if (oh) begin
          m_pos = ix; m_valid = 1;
          m_mode = (ix == W - 1) ? M_DOWN : M_UP;
        end else begin
          e_oh = 1; m_valid = 0;
        end
      end else begin
        d = ix - m_pos;
        if (!oh) begin
          e_oh = 1; m_valid = 0; m_mode = M_FAULT;
        end else if (d == 1 || d == -1) begin
          m_step = 1; m_dir = (d == 1); m_pos = ix;
          m_mode = (d == 1) ? M_UP : M_DOWN;
          if (ix == 0 || ix == W - 1) m_sweep = (m_sweep + 1) % 65536;
        end else begin
          e_j = 1; m_mode = M_FAULT;
        end
      end
    end
`ifdef CYLON_DEC_STICKY_ERR_EN
    m_eoh = m_eoh | e_oh; m_ej = m_ej | e_j; m_est = m_est | e_st;
`else
    m_eoh = e_oh; m_ej = e_j; m_est = e_st;
`endif
    m_prev = m_s1;
    m_s1   = l;
  endtask

  // One clock: advance the model, then compare every output after the edge.
  task automatic cycle();
    model_edge(btnC, led);
    @(posedge clk);
    #1;
    if (step) steps_seen++;
    check("model pos",        32'(pos),         32'(m_pos));
    check("model pos_valid",  32'(pos_valid),   32'(m_valid));
    check("model dir",        32'(dir),         32'(m_dir));
    check("model step",       32'(step),        32'(m_step));
    check("model sweep",      32'(sweep_count), 32'(m_sweep));
    check("model err_onehot", 32'(err_onehot),  32'(m_eoh));
    check("model err_jump",   32'(err_jump),    32'(m_ej));
    check("model err_stall",  32'(err_stall),   32'(m_est));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n_wait;
    int stall_hi;
    int rp;
    int r;
    btnC = 1'b1;
    led  = 16'h0001;
    steps_seen = 0;

    // Reset for two cycles.
    run(2);
    check("reset pos",       32'(pos),         0);
    check("reset pos_valid", 32'(pos_valid),   0);
    check("reset dir",       32'(dir),         0);
    check("reset step",      32'(step),        0);
    check("reset sweep",     32'(sweep_count), 0);
    check("reset errors",    32'({err_onehot, err_jump, err_stall}), 0);
    btnC = 1'b0;

    // Walk up 0x0001 .. 0x8000, one value every 10 cycles.
    steps_seen = 0;
    for (int k = 0; k < W; k++) begin
      led = 16'(1 << k);
      cycle();
      check("walk step early", 32'(step), 0);
      cycle();
      check("walk pos",  32'(pos),  32'(k));
      check("walk step", 32'(step), (k != 0) ? 1 : 0);
      check("walk dir",  32'(dir),  (k != 0) ? 1 : 0);
      run(8);
    end
    check("walk step count", 32'(steps_seen), 15);
    check("walk sweep",      32'(sweep_count), 1);

    // Bounce back down to 0x0001.
    for (int k = W - 2; k >= 0; k--) begin
      led = 16'(1 << k);
      run(2);
      check("bounce pos",  32'(pos),  32'(k));
      check("bounce step", 32'(step), 1);
      check("bounce dir",  32'(dir),  0);
      run(8);
    end
    check("bounce sweep", 32'(sweep_count), 2);

    // Jump 0x0004 -> 0x0040, then recovery.
    led = 16'h0002; run(10);
    led = 16'h0004; run(10);
    led = 16'h0040; run(2);
    check("jump err_jump",   32'(err_jump),  1);
    check("jump step",       32'(step),      0);
    check("jump pos",        32'(pos),       2);
    check("jump pos_valid",  32'(pos_valid), 1);
    cycle();
`ifndef CYLON_DEC_STICKY_ERR_EN
    check("jump pulse width", 32'(err_jump), 0);
`endif
    run(7);
    led = 16'h0080; run(2);
    check("reload pos",  32'(pos),  7);
    check("reload step", 32'(step), 0);
    run(8);
    led = 16'h0100; run(2);
    check("after reload step", 32'(step), 1);
    check("after reload pos",  32'(pos),  8);
    run(8);

    // Not one-hot: zero, then two bits.
    led = 16'h0000; run(2);
    check("zero err_onehot",  32'(err_onehot), 1);
    check("zero pos_valid",   32'(pos_valid),  0);
    run(8);
    led = 16'h0003; run(2);
    check("multi err_onehot", 32'(err_onehot), 1);
    check("multi pos_valid",  32'(pos_valid),  0);
    run(8);

    // Stall: reacquire at 0x0010 and hold.
    led = 16'h0010; run(2);
    check("stall reload pos", 32'(pos), 4);
    n_wait = 0;
    while (!err_stall && n_wait < STALL + 100) begin
      cycle();
      n_wait++;
    end
    check("stall latency", 32'(n_wait), STALL);
    stall_hi = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (err_stall) stall_hi++;
    end
`ifdef CYLON_DEC_STICKY_ERR_EN
    check("stall held", 32'(stall_hi), 50);
`else
    check("stall no re-pulse", 32'(stall_hi), 0);
`endif

    // Reset mid-sweep at pos 9.
    for (int k = 5; k <= 9; k++) begin
      led = 16'(1 << k);
      run(10);
    end
    check("pre-reset pos", 32'(pos), 9);
    btnC = 1'b1;
    cycle();
    check("midreset pos",    32'(pos),         0);
    check("midreset valid",  32'(pos_valid),   0);
    check("midreset sweep",  32'(sweep_count), 0);
    check("midreset dir",    32'(dir),         0);
    btnC = 1'b0;
    run(2);
    check("rejoin pos",    32'(pos),       9);
    check("rejoin valid",  32'(pos_valid), 1);
    check("rejoin step",   32'(step),      0);
    check("rejoin errors", 32'({err_onehot, err_jump, err_stall}), 0);

    // Randomized phase: mostly legal steps, some holds, jumps, junk and resets.
    rp = 9;
    for (int s = 0; s < 400; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        if (rp == 0) rp = 1;
        else if (rp == W - 1) rp = W - 2;
        else rp = ($urandom_range(0, 1) == 1) ? rp + 1 : rp - 1;
        led = 16'(1 << rp);
      end else if (r < 70) begin
        led = led;
      end else if (r < 80) begin
        rp  = int'($urandom_range(0, W - 1));
        led = 16'(1 << rp);
      end else if (r < 97) begin
        led = 16'($urandom);
      end else begin
        btnC = 1'b1;
        cycle();
        btnC = 1'b0;
      end
      run(int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
